// File: rtl/vm1_qbus_ram.sv
// vm1_qbus_ram: Qbus slave word memory with programmable wait states before RPLY
// Ports: pin_clk/pin_dclo_n clock and async active-low reset; pin_init_in sync abort;
// pin_ad_in/pin_sync_in/pin_din_in/pin_dout_in/pin_wtbt_in true-polarity bus inputs;
// pin_ad_out/pin_ad_ena read data and its drive enable; pin_rply_out reply; sel window hit.
module vm1_qbus_ram #(
   parameter logic [15:0] BASE = 16'hE000,
   parameter int AW = 6,
   parameter int WAIT = 1
) (
   input  logic        pin_clk,
   input  logic        pin_dclo_n,
   input  logic        pin_init_in,
   input  logic [15:0] pin_ad_in,
   output logic [15:0] pin_ad_out,
   output logic        pin_ad_ena,
   input  logic        pin_sync_in,
   input  logic        pin_din_in,
   input  logic        pin_dout_in,
   input  logic        pin_wtbt_in,
   output logic        pin_rply_out,
   output logic        sel
);
   typedef enum logic [2:0] {IDLE, ADDR, WAITS, RD, WR, HOLD} state_t;
   state_t state, state_nx;
   logic [AW:0] a, a_nx;
   logic [3:0] cnt, cnt_nx;
   logic rd, rd_nx, ena_nx, rply_nx, sel_nx, we;
   logic [15:0] ad_nx;
   logic [15:0] mem [2**AW];
   logic hit;
   assign hit = pin_ad_in[15:AW+1] == BASE[15:AW+1];
   always_comb begin
      state_nx = state;
      a_nx = a;
      cnt_nx = cnt;
      rd_nx = rd;
      ad_nx = pin_ad_out;
      ena_nx = pin_ad_ena;
      rply_nx = pin_rply_out;
      sel_nx = sel;
      we = 1'b0;
      if (pin_init_in || (!pin_sync_in && state != IDLE && state != HOLD)) begin
         state_nx = IDLE;
         cnt_nx = '0;
         ad_nx = '0;
         ena_nx = 1'b0;
         rply_nx = 1'b0;
         sel_nx = 1'b0;
      end else begin
         case (state)
            IDLE: if (pin_sync_in) begin
               a_nx = pin_ad_in[AW:0];
               state_nx = hit ? ADDR : HOLD;
               sel_nx = hit;
            end
            ADDR: if (pin_din_in || pin_dout_in) begin
               state_nx = WAITS;
               cnt_nx = 4'(WAIT);
               rd_nx = pin_din_in;
            end
            WAITS: if (cnt == 4'd0) begin
               state_nx = rd ? RD : WR;
               ad_nx = rd ? mem[a[AW:1]] : pin_ad_out;
               ena_nx = rd;
               rply_nx = 1'b1;
               we = !rd;
            end else cnt_nx = cnt - 4'd1;
            RD: if (!pin_din_in) begin
               state_nx = ADDR;
               rply_nx = 1'b0;
               ena_nx = 1'b0;
            end
            WR: if (!pin_dout_in) begin
               state_nx = ADDR;
               rply_nx = 1'b0;
            end
            HOLD: state_nx = pin_sync_in ? HOLD : IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end
   always_ff @(posedge pin_clk or negedge pin_dclo_n)
      if (!pin_dclo_n) begin
         state <= IDLE;
         a <= '0;
         cnt <= '0;
         rd <= 1'b0;
         pin_ad_out <= '0;
         pin_ad_ena <= 1'b0;
         pin_rply_out <= 1'b0;
         sel <= 1'b0;
      end else begin
         state <= state_nx;
         a <= a_nx;
         cnt <= cnt_nx;
         rd <= rd_nx;
         pin_ad_out <= ad_nx;
         pin_ad_ena <= ena_nx;
         pin_rply_out <= rply_nx;
         sel <= sel_nx;
      end
   // byte lane chosen by address bit 0 when WTBT marks a byte write
   always_ff @(posedge pin_clk)
      if (we)
         mem[a[AW:1]] <= !pin_wtbt_in ? pin_ad_in :
                         a[0] ? {pin_ad_in[15:8], mem[a[AW:1]][7:0]} :
                                {mem[a[AW:1]][15:8], pin_ad_in[7:0]};
endmodule

// File: tb/tb_vm1_qbus_ram.sv
// tb_vm1_qbus_ram: directed bench driving three instances (WAIT=0,1,5) on one shared bus
module tb_vm1_qbus_ram;
   logic clk = 0, dclo_n = 0, init = 0, sync = 0, din = 0, dout = 0, wtbt = 0;
   logic [15:0] ad = '0;
   logic [15:0] ad_o [3];
   logic ena_o [3], rply_o [3], sel_o [3];
   int ds = 1, checks = 0, failures = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 3; g++) begin : g_dut
      vm1_qbus_ram #(.BASE(16'hE000), .AW(6), .WAIT(g == 0 ? 0 : g == 1 ? 1 : 5)) u (
         .pin_clk(clk), .pin_dclo_n(dclo_n), .pin_init_in(init), .pin_ad_in(ad),
         .pin_ad_out(ad_o[g]), .pin_ad_ena(ena_o[g]), .pin_sync_in(sync),
         .pin_din_in(din), .pin_dout_in(dout), .pin_wtbt_in(wtbt),
         .pin_rply_out(rply_o[g]), .sel(sel_o[g]));
   end
   typedef struct {logic wr; logic [15:0] addr; logic [15:0] data; logic wtbt; logic [15:0] exp;} vec_t;
   vec_t tv [10];
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s ds=%0d act=%h exp=%h", name, ds, act, exp);
      end
   endtask
   function automatic int lat();
      return (ds == 0 ? 0 : ds == 1 ? 1 : 5) + 2;
   endfunction
   task automatic wait_rply(input string name);
      int got = 0;
      for (int k = 1; k <= 40; k++) begin
         tick;
         if (rply_o[ds]) begin
            got = k;
            break;
         end
      end
      chk(name, 16'(got), 16'(lat()));
   endtask
   task automatic start(input logic [15:0] addr);
      ad = addr;
      sync = 1;
      tick;
      ad = '0;
   endtask
   task automatic dati(input logic [15:0] addr, input logic [15:0] exp, input string name);
      start(addr);
      din = 1;
      wait_rply({name, "_lat"});
      chk({name, "_data"}, ad_o[ds], exp);
      chk({name, "_ena"}, 16'(ena_o[ds]), 16'd1);
      chk({name, "_sel"}, 16'(sel_o[ds]), 16'd1);
      tick;
      chk({name, "_hold"}, 16'({rply_o[ds], ena_o[ds]}), 16'd3);
      din = 0;
      tick;
      chk({name, "_release"}, 16'({rply_o[ds], ena_o[ds]}), 16'd0);
      sync = 0;
      tick;
   endtask
   task automatic dato(input logic [15:0] addr, input logic [15:0] data, input logic bt, input string name);
      start(addr);
      ad = data;
      wtbt = bt;
      dout = 1;
      wait_rply({name, "_lat"});
      dout = 0;
      tick;
      chk({name, "_release"}, 16'(rply_o[ds]), 16'd0);
      sync = 0;
      wtbt = 0;
      ad = '0;
      tick;
   endtask
   initial begin
      logic bad;
      tv[0] = '{1'b1, 16'hE004, 16'h1234, 1'b0, 16'h0};
      tv[1] = '{1'b0, 16'hE004, 16'h0, 1'b0, 16'h1234};
      tv[2] = '{1'b1, 16'hE010, 16'hAAAA, 1'b0, 16'h0};
      tv[3] = '{1'b1, 16'hE011, 16'h5500, 1'b1, 16'h0};
      tv[4] = '{1'b0, 16'hE010, 16'h0, 1'b0, 16'h55AA};
      tv[5] = '{1'b1, 16'hE010, 16'h0033, 1'b1, 16'h0};
      tv[6] = '{1'b0, 16'hE011, 16'h0, 1'b0, 16'h5533};
      tv[7] = '{1'b1, 16'hE07E, 16'hBEEF, 1'b0, 16'h0};
      tv[8] = '{1'b0, 16'hE07E, 16'h0, 1'b0, 16'hBEEF};
      tv[9] = '{1'b0, 16'hE004, 16'h0, 1'b0, 16'h1234};
      #1;
      chk("reset_outputs", ad_o[1] | 16'({ena_o[1], rply_o[1], sel_o[1]}), 16'd0);
      repeat (2) tick;
      dclo_n = 1;
      tick;
      ds = 1;
      for (int i = 0; i < 10; i++)
         if (tv[i].wr) dato(tv[i].addr, tv[i].data, tv[i].wtbt, $sformatf("vec%0d_wr", i));
         else dati(tv[i].addr, tv[i].exp, $sformatf("vec%0d_rd", i));
      ds = 0;
      dati(16'hE004, 16'h1234, "wait0_rd");
      ds = 2;
      dato(16'hE030, 16'h1111, 1'b0, "wait5_wr");
      dati(16'hE030, 16'h1111, "wait5_rd");
      ds = 1;
      foreach (tv[i]) if (i < 2) begin
         start(i == 0 ? 16'hDFFE : 16'hE080);
         din = 1;
         bad = 0;
         for (int k = 0; k < 50; k++) begin
            tick;
            bad |= sel_o[1] | rply_o[1] | ena_o[1];
         end
         chk(i == 0 ? "miss_dffe" : "miss_e080", 16'(bad), 16'd0);
         din = 0;
         sync = 0;
         tick;
      end
      start(16'hE084);
      ad = 16'hDEAD;
      dout = 1;
      repeat (10) tick;
      chk("miss_wr_quiet", 16'({sel_o[1], rply_o[1]}), 16'd0);
      dout = 0;
      sync = 0;
      ad = '0;
      tick;
      dati(16'hE004, 16'h1234, "miss_mem_intact");
      dato(16'hE020, 16'h0007, 1'b0, "datio_pre");
      start(16'hE020);
      din = 1;
      wait_rply("datio_rd_lat");
      chk("datio_rd_data", ad_o[1], 16'h0007);
      din = 0;
      tick;
      chk("datio_rd_release", 16'(rply_o[1]), 16'd0);
      ad = 16'h0008;
      dout = 1;
      wait_rply("datio_wr_lat");
      dout = 0;
      tick;
      sync = 0;
      ad = '0;
      tick;
      dati(16'hE020, 16'h0008, "datio_readback");
      ds = 2;
      start(16'hE030);
      ad = 16'hFFFF;
      dout = 1;
      repeat (3) tick;
      chk("abort_pre_sel", 16'({sel_o[2], rply_o[2]}), 16'd2);
      sync = 0;
      tick;
      chk("abort_outputs", ad_o[2] | 16'({ena_o[2], rply_o[2], sel_o[2]}), 16'd0);
      dout = 0;
      ad = '0;
      tick;
      dati(16'hE030, 16'h1111, "abort_mem_kept");
      ds = 1;
      start(16'hE004);
      din = 1;
      wait_rply("init_pre_lat");
      init = 1;
      tick;
      chk("init_outputs", ad_o[1] | 16'({ena_o[1], rply_o[1], sel_o[1]}), 16'd0);
      init = 0;
      din = 0;
      sync = 0;
      tick;
      dati(16'hE004, 16'h1234, "init_mem_kept");
      start(16'hE004);
      din = 1;
      wait_rply("dclo_pre_lat");
      #2 dclo_n = 0;
      #1;
      chk("dclo_async", ad_o[1] | 16'({ena_o[1], rply_o[1], sel_o[1]}), 16'd0);
      din = 0;
      sync = 0;
      tick;
      dclo_n = 1;
      tick;
      dati(16'hE004, 16'h1234, "dclo_mem_kept");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/vm1_qbus_ram.md
Name: vm1_qbus_ram

Overview:
- Qbus slave memory block sitting directly downstream of the vm1_qbus core on the shared bus. It consumes the true-polarity Qbus signals that the core produces.
- Decodes the address latched at SYNC and serves DATI, DATO(B) and DATIO(B) cycles from an internal word array.
- Answers with RPLY after a programmable number of wait states.
- Same clock domain as the core; bus inputs are sampled directly, with no synchronizers.

Parameters:
- BASE, 16'hE000, byte base address of the window; must be aligned to the window size.
- AW, 6, word address width; window = 2^AW words = 2^(AW+1) bytes.
- WAIT, 1, wait states inserted before RPLY (0..15).

Ports:
- pin_clk  input  1  processor clock; all state changes on the rising edge.
- pin_dclo_n  input  1  asynchronous active-low reset.
- pin_init_in  input  1  bus INIT, active high; synchronous abort.
- pin_ad_in  input  16  address/data from the bus, true polarity.
- pin_ad_out  output  16  read data to the bus.
- pin_ad_ena  output  1  high while pin_ad_out drives the bus.
- pin_sync_in  input  1  address strobe.
- pin_din_in  input  1  data input strobe (master reads).
- pin_dout_in  input  1  data output strobe (master writes).
- pin_wtbt_in  input  1  byte flag, sampled in the data phase.
- pin_rply_out  output  1  transaction reply.
- sel  output  1  high while the current cycle addresses this window (debug/status).

Behaviour:
- Reset (pin_dclo_n=0), effective immediately:
  - pin_ad_out=0, pin_ad_ena=0, pin_rply_out=0, sel=0; FSM to IDLE; wait counter cleared.
  - Memory contents are not reset.
- pin_init_in=1, sampled: same effect as reset on the next edge, memory untouched. It overrides every other input.
- All outputs are registered.
- FSM states: IDLE, ADDR, WAITS, RD, WR, HOLD.
- IDLE:
  - Stays in IDLE while pin_sync_in=0.
  - On the first edge with pin_sync_in=1, latch a=pin_ad_in.
  - Hit = (a[15:AW+1] == BASE[15:AW+1]).
  - Hit: go to ADDR and set sel=1. Miss: go to HOLD with no response.
- ADDR:
  - pin_din_in=1: load counter=WAIT and go to WAITS, marked read.
  - Else pin_dout_in=1: go to WAITS, marked write.
  - DIN wins if both strobes are high.
- WAITS:
  - Counter decrements each cycle. When the counter is 0, go to RD or WR.
  - With WAIT=0 this state takes exactly one cycle.
- RD:
  - On entry: pin_ad_out=mem[a[AW:1]], pin_ad_ena=1, pin_rply_out=1.
  - Read data is always a full word; a[0] is ignored.
  - Hold these outputs until pin_din_in=0 is sampled. Then clear pin_rply_out and pin_ad_ena on that edge and go to ADDR, so DATIO can follow.
- WR:
  - On entry the write is performed once, using the pin_ad_in and pin_wtbt_in values sampled on that edge, and pin_rply_out=1.
  - pin_wtbt_in=0: mem word = pin_ad_in.
  - pin_wtbt_in=1, a[0]=0: write low byte from pin_ad_in[7:0]; high byte kept.
  - pin_wtbt_in=1, a[0]=1: write high byte from pin_ad_in[15:8]; low byte kept.
  - Hold pin_rply_out until pin_dout_in=0 is sampled, then clear it and go to ADDR.
- HOLD (miss): outputs stay idle; return to IDLE when pin_sync_in=0.
- SYNC drop (pin_sync_in=0 sampled in ADDR, WAITS, RD or WR):
  - Abort to IDLE; clear pin_rply_out, pin_ad_ena and sel on that edge.
  - A write whose WR entry has not yet occurred is discarded.
- Latency, read: strobe sampled high at edge N gives pin_rply_out=1 after edge N+WAIT+1.
- Latency, write: the write lands at edge N+WAIT+1.
- RPLY never asserts unless sel=1.
- A new cycle is recognised only after pin_sync_in returns to 0, so back-to-back cycles need one idle SYNC-low cycle.

Test Plan:
- Word write then read (WAIT=1): DATO addr E004, data 1234 → RPLY 2 edges after DOUT. DATI E004 → pin_ad_out=1234 with pin_ad_ena=1 until DIN drops.
- Byte writes: word E010=AAAA, then DATOB E011 data 5500 with wtbt=1 → read gives 55AA. Then DATOB E010 data 0033 → read gives 5533.
- Wait states: WAIT=0 → RPLY one edge after strobe. WAIT=5 → RPLY six edges after strobe. Counted with an exact cycle monitor.
- Miss: DATI at DFFE or at E080 (AW=6) → sel=0, no RPLY, no pin_ad_ena, no memory change, for 50 cycles.
- DATIO: SYNC E020 holding 0007, DIN → 0007; then DOUT 0008 inside the same SYNC → second RPLY; a later read gives 0008.
- Abort: INIT pulse, or SYNC drop during WAITS with WAIT=5 on a write of FFFF → all outputs 0 on the next edge; the word keeps its old value.
- Reset: pin_dclo_n low mid-RD → outputs 0 immediately, with no pin_clk edge needed.
